cpsr_unit: RTL and testbench
============================

# cpsr_unit

Architectural status register block for the ARM7TDMI core. It holds the CPSR and the five banked SPSRs, and applies ALU flag updates, MSR writes, exception entry and SPSR restore. It is the producer side of the flag interface: its `cpsr` output feeds the instruction condition check, and `cpsr_next` is the same-cycle forward path. It also tells the register file when the processor mode changes.

## Interface
Parameters:
- `RESET_CPSR`, 32'h0000_00D3: CPSR value at reset (SVC mode, I=1, F=1, T=0).

Ports:
- `clk`  in  1: core clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `flag_we`  in  4: per-flag write enables, {N,Z,C,V}.
- `flag_in`  in  4: new flag values, {N,Z,C,V}.
- `msr_valid`  in  1: MSR request.
- `msr_spsr`  in  1: MSR target; 1 = SPSR of current mode, 0 = CPSR.
- `msr_mask`  in  4: field mask {f,s,x,c}, covering bits [31:24], [23:16], [15:8], [7:0].
- `msr_data`  in  32: MSR operand.
- `restore_valid`  in  1: copy SPSR of current mode to CPSR (S-suffixed write to PC).
- `exc_valid`  in  1: exception entry.
- `exc_mode`  in  5: target mode of the exception.
- `exc_set_f`  in  1: also set the F bit (reset, FIQ).
- `cpsr`  out  32: registered CPSR.
- `cpsr_next`  out  32: combinational value CPSR will take at the next edge.
- `spsr`  out  32: registered SPSR of the current mode.
- `mode_changed`  out  1: one-cycle pulse after any CPSR mode change.

## Operation
- Valid modes:
  - USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111.
  - FIQ, IRQ, SVC, ABT and UND each own an SPSR. USR and SYS have none.
- Bits [27:8] of the CPSR and of every SPSR are hardwired to zero. Writes to them are discarded.
- Priority per cycle is exc > restore > MSR > flag update. The winning event suppresses all lower ones entirely in that cycle.
- Exception entry:
  - The SPSR of `exc_mode` is loaded with the old CPSR.
  - CPSR[4:0] is set to `exc_mode`, T=0 and I=1.
  - F is set to 1 if `exc_set_f`; otherwise F is unchanged.
  - N, Z, C and V are unchanged.
  - An invalid `exc_mode`, USR or SYS makes the request ignored.
- Restore:
  - CPSR is loaded with the SPSR of the current mode.
  - The request is ignored in USR/SYS, or if the SPSR mode field is invalid.
- MSR to CPSR:
  - The f field is always writable.
  - The c field is writable only in privileged modes (not USR).
  - Bit 5 (T) is always preserved.
  - A c-field write carrying an invalid mode drops the c-field portion only.
- MSR to SPSR:
  - The masked fields of the current mode's SPSR are written; any mode value is accepted.
  - The write is ignored in USR/SYS.
- Flag update: each CPSR[31:28] bit whose `flag_we` bit is set takes the matching `flag_in` bit.
- `spsr` output:
  - Shows the SPSR of the current registered mode.
  - In USR/SYS it reads as the current `cpsr`.
- `cpsr_next` equals `cpsr` when no event wins in the cycle.

## Timing
- Reset (asynchronous):
  - `cpsr` = `RESET_CPSR`, all SPSRs = 0, `mode_changed` = 0.
  - `spsr` = 0, because the SVC SPSR is 0.
- Every accepted update is visible on `cpsr`/`spsr` one cycle after the request edge.
- `cpsr_next` reflects it combinationally in the request cycle, so the condition check can forward it with zero latency.
- `mode_changed` is high for exactly the one cycle following the edge at which CPSR[4:0] changed value. A write of the same mode gives no pulse.
- Back-to-back requests on consecutive cycles are each applied in order. There are no stalls and no busy state.
- Reset asserted mid-cycle overrides any pending request. The first edge after deassertion processes inputs normally.

## Test plan
- Reset:
  - Assert `rst_n`=0, then release → `cpsr`=0x000000D3, `spsr`=0, `mode_changed`=0.
  - Apply `flag_we`=1111, `flag_in`=1010 → `cpsr`=0xA00000D3 next cycle.
  - `cpsr_next`=0xA00000D3 in the request cycle itself.
- Exception entry and return:
  - From CPSR 0x6000001F (SYS), raise `exc_valid` with `exc_mode`=10010 → `cpsr`=0x60000092, IRQ SPSR=0x6000001F, `mode_changed` pulses one cycle.
  - Then `restore_valid` → `cpsr`=0x6000001F, `mode_changed` pulses again.
- USR protection:
  - In USR, MSR CPSR with mask 1001 and data 0xF00000D3 → `cpsr`=0xF0000010.
  - MSR SPSR in USR is ignored.
  - `restore_valid` in USR is ignored.
- Simultaneous events:
  - Assert `exc_valid` (FIQ, `exc_set_f`=1), `msr_valid` and `flag_we`=1111 in the same cycle.
  - Required: only the exception applies; CPSR flags unchanged, F=1.
- MSR edge cases:
  - MSR CPSR with c field and mode 00000 in SVC → mode stays 10011, f field still written.
  - MSR CPSR with bit 5 set → T stays 0.
  - MSR CPSR with data 0xFFFFFFFF and mask 1111 in SVC → bits [27:8] read 0.

Source files
------------

// File: rtl/cpsr_unit.sv
// cpsr_unit: ARM7TDMI CPSR and banked SPSR storage. Applies exception
// entry, SPSR restore, MSR writes and ALU flag updates, in that priority.
module cpsr_unit #(
   parameter logic [31:0] RESET_CPSR = 32'h0000_00D3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  flag_we,
   input  logic [3:0]  flag_in,
   input  logic        msr_valid,
   input  logic        msr_spsr,
   input  logic [3:0]  msr_mask,
   input  logic [31:0] msr_data,
   input  logic        restore_valid,
   input  logic        exc_valid,
   input  logic [4:0]  exc_mode,
   input  logic        exc_set_f,
   output logic [31:0] cpsr,
   output logic [31:0] cpsr_next,
   output logic [31:0] spsr,
   output logic        mode_changed
);

   // Only flags [31:28] and the control byte [7:0] exist; [27:8] read as zero.
   localparam logic [31:0] IMPL_BITS = 32'hF000_00FF;

   localparam logic [4:0] MODE_USR = 5'b10000;
   localparam logic [4:0] MODE_FIQ = 5'b10001;
   localparam logic [4:0] MODE_IRQ = 5'b10010;
   localparam logic [4:0] MODE_SVC = 5'b10011;
   localparam logic [4:0] MODE_ABT = 5'b10111;
   localparam logic [4:0] MODE_UND = 5'b11011;
   localparam logic [4:0] MODE_SYS = 5'b11111;

   function automatic logic mode_valid(input logic [4:0] m);
      case (m)
         MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
         MODE_ABT, MODE_UND, MODE_SYS: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

   // Exception modes are exactly the ones owning a banked SPSR.
   function automatic logic has_spsr(input logic [4:0] m);
      case (m)
         MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND: return 1'b1;
         default:                                          return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] bank_idx(input logic [4:0] m);
      case (m)
         MODE_FIQ: return 3'd0;
         MODE_IRQ: return 3'd1;
         MODE_SVC: return 3'd2;
         MODE_ABT: return 3'd3;
         default:  return 3'd4;
      endcase
   endfunction

   logic [31:0] cpsr_reg;
   logic        mode_changed_reg;
   logic [31:0] spsr_bank [0:4];

   logic [4:0]  cur_mode;
   logic [31:0] cur_spsr;
   logic [31:0] field_mask;
   logic [31:0] msr_cpsr_mask;
   logic [31:0] msr_cpsr_val;
   logic [31:0] msr_spsr_val;
   logic [31:0] exc_val;
   logic [31:0] flag_val;
   logic [4:0]  bank_we;
   logic [31:0] bank_wdata;

   // Candidate values for each kind of update, computed in parallel.
   always_comb begin
      cur_mode   = cpsr_reg[4:0];
      cur_spsr   = spsr_bank[bank_idx(cur_mode)];
      field_mask = {{8{msr_mask[3]}}, {8{msr_mask[2]}},
                    {8{msr_mask[1]}}, {8{msr_mask[0]}}};
      msr_cpsr_mask = field_mask;
      // User mode may not touch the control byte, and an invalid mode
      // discards the whole control-byte portion of the write.
      if (cur_mode == MODE_USR || !mode_valid(msr_data[4:0]))
         msr_cpsr_mask[7:0] = 8'h00;
      // The Thumb bit only changes through BX / exception entry / restore.
      msr_cpsr_mask[5] = 1'b0;
      msr_cpsr_val = ((cpsr_reg & ~msr_cpsr_mask) | (msr_data & msr_cpsr_mask)) & IMPL_BITS;
      msr_spsr_val = ((cur_spsr & ~field_mask) | (msr_data & field_mask)) & IMPL_BITS;
      exc_val      = {cpsr_reg[31:8], 1'b1, cpsr_reg[6] | exc_set_f, 1'b0, exc_mode};
      flag_val     = {(cpsr_reg[31:28] & ~flag_we) | (flag_in & flag_we), cpsr_reg[27:0]};
   end

   // Priority select: exception > restore > MSR > flags. A request that
   // would be ignored does not claim the cycle.
   always_comb begin
      cpsr_next  = cpsr_reg;
      bank_we    = '0;
      bank_wdata = '0;
      if (exc_valid && has_spsr(exc_mode)) begin
         cpsr_next                   = exc_val;
         bank_we[bank_idx(exc_mode)] = 1'b1;
         bank_wdata                  = cpsr_reg;
      end else if (restore_valid && has_spsr(cur_mode) && mode_valid(cur_spsr[4:0])) begin
         cpsr_next = cur_spsr;
      end else if (msr_valid && !msr_spsr) begin
         cpsr_next = msr_cpsr_val;
      end else if (msr_valid && msr_spsr && has_spsr(cur_mode)) begin
         bank_we[bank_idx(cur_mode)] = 1'b1;
         bank_wdata                  = msr_spsr_val;
      end else if (|flag_we) begin
         cpsr_next = flag_val;
      end
   end

   // CPSR register and the mode-change pulse for the register file.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpsr_reg         <= RESET_CPSR;
         mode_changed_reg <= 1'b0;
      end else begin
         cpsr_reg         <= cpsr_next;
         mode_changed_reg <= (cpsr_next[4:0] != cpsr_reg[4:0]);
      end
   end

   // Banked SPSRs: FIQ, IRQ, SVC, ABT, UND.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 5; i++) spsr_bank[i] <= '0;
      end else begin
         for (int i = 0; i < 5; i++)
            if (bank_we[i]) spsr_bank[i] <= bank_wdata;
      end
   end

   assign cpsr         = cpsr_reg;
   assign spsr         = has_spsr(cur_mode) ? cur_spsr : cpsr_reg;
   assign mode_changed = mode_changed_reg;

endmodule

// File: tb/tb_cpsr_unit.sv
// tb_cpsr_unit: directed plus random stimulus for cpsr_unit, checked
// against a mode-indexed behavioural model of the status registers.
module tb_cpsr_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  flag_we = '0;
   logic [3:0]  flag_in = '0;
   logic        msr_valid = 1'b0;
   logic        msr_spsr = 1'b0;
   logic [3:0]  msr_mask = '0;
   logic [31:0] msr_data = '0;
   logic        restore_valid = 1'b0;
   logic        exc_valid = 1'b0;
   logic [4:0]  exc_mode = '0;
   logic        exc_set_f = 1'b0;
   logic [31:0] cpsr;
   logic [31:0] cpsr_next;
   logic [31:0] spsr;
   logic        mode_changed;

   always #5 clk = ~clk;

   cpsr_unit #(.RESET_CPSR(32'h0000_00D3)) dut (
      .clk(clk), .rst_n(rst_n),
      .flag_we(flag_we), .flag_in(flag_in),
      .msr_valid(msr_valid), .msr_spsr(msr_spsr), .msr_mask(msr_mask), .msr_data(msr_data),
      .restore_valid(restore_valid),
      .exc_valid(exc_valid), .exc_mode(exc_mode), .exc_set_f(exc_set_f),
      .cpsr(cpsr), .cpsr_next(cpsr_next), .spsr(spsr), .mode_changed(mode_changed)
   );

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   // Model: CPSR plus one SPSR slot per 5-bit mode value.
   logic [31:0] m_cpsr;
   logic [31:0] m_spsr [32];
   logic        m_mc;
   logic [31:0] p_cpsr;
   int          p_bank;
   logic [31:0] p_val;

   logic [4:0] all_modes [7] = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F};
   logic [4:0] exc_modes [5] = '{5'h11, 5'h12, 5'h13, 5'h17, 5'h1B};

   function automatic bit is_mode(input logic [4:0] m);
      return m inside {5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F};
   endfunction

   function automatic bit owns_spsr(input logic [4:0] m);
      return m inside {5'h11, 5'h12, 5'h13, 5'h17, 5'h1B};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cpsr = 32'h0000_00D3;
      for (int i = 0; i < 32; i++) m_spsr[i] = '0;
      m_mc = 1'b0;
   endtask

   task automatic clear_inputs();
      flag_we = '0; flag_in = '0;
      msr_valid = 1'b0; msr_spsr = 1'b0; msr_mask = '0; msr_data = '0;
      restore_valid = 1'b0;
      exc_valid = 1'b0; exc_mode = '0; exc_set_f = 1'b0;
   endtask

   // Work out the effect of the current inputs from the architectural rules.
   task automatic predict();
      logic [4:0]  cur;
      logic [31:0] v;
      cur    = m_cpsr[4:0];
      p_cpsr = m_cpsr;
      p_bank = -1;
      p_val  = '0;
      if (exc_valid && owns_spsr(exc_mode)) begin
         p_bank      = int'(exc_mode);
         p_val       = m_cpsr;
         p_cpsr[4:0] = exc_mode;
         p_cpsr[5]   = 1'b0;
         p_cpsr[7]   = 1'b1;
         if (exc_set_f) p_cpsr[6] = 1'b1;
      end else if (restore_valid && owns_spsr(cur) && is_mode(m_spsr[cur][4:0])) begin
         p_cpsr = m_spsr[cur];
      end else if (msr_valid && !msr_spsr) begin
         v = m_cpsr;
         for (int b = 0; b < 4; b++)
            if (msr_mask[b] && !(b == 0 && cur == 5'h10)) v[b*8 +: 8] = msr_data[b*8 +: 8];
         if (msr_mask[0] && cur != 5'h10 && !is_mode(msr_data[4:0])) v[7:0] = m_cpsr[7:0];
         v[5]    = m_cpsr[5];
         v[27:8] = '0;
         p_cpsr  = v;
      end else if (msr_valid && msr_spsr && owns_spsr(cur)) begin
         v = m_spsr[cur];
         for (int b = 0; b < 4; b++)
            if (msr_mask[b]) v[b*8 +: 8] = msr_data[b*8 +: 8];
         v[27:8] = '0;
         p_bank  = int'(cur);
         p_val   = v;
      end else begin
         for (int i = 0; i < 4; i++)
            if (flag_we[i]) p_cpsr[28+i] = flag_in[i];
      end
   endtask

   function automatic logic [31:0] exp_spsr();
      return owns_spsr(m_cpsr[4:0]) ? m_spsr[m_cpsr[4:0]] : m_cpsr;
   endfunction

   // One cycle: check the forward path, clock, then check the registered state.
   task automatic step(input string tag);
      predict();
      #1;
      check($sformatf("%s.cpsr_next", tag), cpsr_next, p_cpsr);
      @(posedge clk);
      #1;
      m_mc   = (p_cpsr[4:0] != m_cpsr[4:0]);
      m_cpsr = p_cpsr;
      if (p_bank >= 0) m_spsr[p_bank] = p_val;
      clear_inputs();
      check($sformatf("%s.cpsr", tag), cpsr, m_cpsr);
      check($sformatf("%s.spsr", tag), spsr, exp_spsr());
      check($sformatf("%s.mode_changed", tag), {31'b0, mode_changed}, {31'b0, m_mc});
   endtask

   task automatic set_msr(input logic tgt, input logic [3:0] mask, input logic [31:0] data);
      msr_valid = 1'b1; msr_spsr = tgt; msr_mask = mask; msr_data = data;
   endtask

   task automatic set_exc(input logic [4:0] mode, input logic setf);
      exc_valid = 1'b1; exc_mode = mode; exc_set_f = setf;
   endtask

   initial begin
      int kind;
      model_reset();
      clear_inputs();
      #12;
      check("reset.cpsr", cpsr, m_cpsr);
      check("reset.spsr", spsr, 32'h0);
      check("reset.mode_changed", {31'b0, mode_changed}, 32'h0);
      rst_n = 1'b1;

      flag_we = 4'b1111; flag_in = 4'b1010;
      step("flags");
      check("flags.const", cpsr, 32'hA000_00D3);

      set_msr(1'b0, 4'b1001, 32'h6000_001F);
      step("to_sys");
      set_exc(5'b10010, 1'b0);
      step("exc_irq");
      check("exc_irq.const", cpsr, 32'h6000_0092);
      check("exc_irq.spsr_const", spsr, 32'h6000_001F);
      step("idle");
      restore_valid = 1'b1;
      step("restore");
      check("restore.const", cpsr, 32'h6000_001F);

      set_msr(1'b0, 4'b0001, 32'h0000_0010);
      step("to_usr");
      set_msr(1'b0, 4'b1001, 32'hF000_00D3);
      step("usr_msr");
      check("usr_msr.const", cpsr, 32'hF000_0010);
      set_msr(1'b1, 4'b1111, 32'h1234_5678);
      step("usr_msr_spsr");
      restore_valid = 1'b1;
      step("usr_restore");

      set_exc(5'b10011, 1'b0);
      step("exc_svc");
      set_exc(5'b10001, 1'b1);
      set_msr(1'b0, 4'b1111, 32'h0000_0000);
      flag_we = 4'b1111; flag_in = 4'b0000;
      step("simul");
      check("simul.const", cpsr, 32'hF000_00D1);
      restore_valid = 1'b1;
      step("fiq_ret");

      set_msr(1'b0, 4'b1001, 32'h5000_0000);
      step("bad_mode");
      check("bad_mode.const", cpsr, 32'h5000_0093);
      set_msr(1'b0, 4'b0001, 32'h0000_00F3);
      step("t_bit");
      check("t_bit.const", {31'b0, cpsr[5]}, 32'h0);
      set_msr(1'b0, 4'b1111, 32'hFFFF_FFFF);
      step("all_ones");
      check("all_ones.zero_bits", {12'b0, cpsr[27:8]}, 32'h0);

      // Reset in the middle of a cycle with a request pending.
      flag_we = 4'b1111; flag_in = 4'b0101;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("midrst.cpsr", cpsr, 32'h0000_00D3);
      check("midrst.spsr", spsr, 32'h0);
      check("midrst.mode_changed", {31'b0, mode_changed}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("post_rst");

      for (int n = 0; n < 300; n++) begin
         kind = int'($urandom_range(0, 5));
         case (kind)
            1: begin
               flag_we = 4'($urandom()); flag_in = 4'($urandom());
            end
            2: begin
               set_exc(exc_modes[$urandom_range(0, 4)], 1'($urandom()));
               restore_valid = 1'($urandom());
               if ($urandom_range(0, 1) == 1) set_msr(1'($urandom()), 4'($urandom()), $urandom());
               flag_we = 4'($urandom()); flag_in = 4'($urandom());
            end
            3: restore_valid = 1'b1;
            4, 5: begin
               msr_data = $urandom();
               if ($urandom_range(0, 3) != 0) msr_data[4:0] = all_modes[$urandom_range(0, 6)];
               set_msr((kind == 4) ? 1'($urandom()) : 1'b0, 4'($urandom()), msr_data);
               if (kind == 5) begin
                  flag_we = 4'($urandom()); flag_in = 4'($urandom());
               end
            end
            default: ;
         endcase
         step($sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
